// File: rtl/contador_ad_bcd_rep_pkg.sv
// Shared definitions for the BCD field counters of the clock/date setting path.
package contador_ad_bcd_rep_pkg;

   localparam int BCD_W = 4;

   // Field select codes driven on en_count by the setting FSM
   localparam logic [3:0] FIELD_SEG = 4'd1;
   localparam logic [3:0] FIELD_MIN = 4'd2;
   localparam logic [3:0] FIELD_HOR = 4'd3;
   localparam logic [3:0] FIELD_DIA = 4'd4;
   localparam logic [3:0] FIELD_MES = 4'd5;
   localparam logic [3:0] FIELD_ANO = 4'd6;

   // Press / auto-repeat FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } rep_state_t;

   // Elaboration-time conversion of a 0..99 constant to two BCD digits
   function automatic logic [2*BCD_W-1:0] to_bcd(input int v);
      logic [2*BCD_W-1:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

endpackage

// File: rtl/contador_ad_bcd_rep_bcd_step2.sv
// Combinational one-step BCD up/down for a 2-digit field with wrap detection.
module bcd_step2
   import contador_ad_bcd_rep_pkg::*;
#(
   parameter logic [7:0] MIN_B = 8'h00,
   parameter logic [7:0] MAX_B = 8'h59
) (
   input  logic [7:0] val,
   input  logic       up,
   output logic [7:0] nxt,
   output logic       wrap
);

   // Digit-wise increment/decrement; range ends wrap to the opposite end
   always_comb begin
      nxt  = val;
      wrap = 1'b0;
      if (up) begin
         if (val == MAX_B) begin
            nxt  = MIN_B;
            wrap = 1'b1;
         end else if (val[3:0] == 4'd9) begin
            nxt = {val[7:4] + 4'd1, 4'd0};
         end else begin
            nxt = {val[7:4], val[3:0] + 4'd1};
         end
      end else begin
         if (val == MIN_B) begin
            nxt  = MAX_B;
            wrap = 1'b1;
         end else if (val[3:0] == 4'd0) begin
            nxt = {val[7:4] - 4'd1, 4'd9};
         end else begin
            nxt = {val[7:4], val[3:0] - 4'd1};
         end
      end
   end

endmodule

// File: rtl/contador_ad_bcd_rep.sv
// 2-digit BCD up/down field counter with press/auto-repeat stepping,
// validated parallel load and carry/borrow chaining between fields.
module contador_ad_bcd_rep
   import contador_ad_bcd_rep_pkg::*;
#(
   parameter int MOD        = 60,
   parameter int MIN_VAL    = 0,
   parameter int FIELD_ID   = 2,
   parameter int REPEAT_DLY = 50_000_000,
   parameter int REPEAT_PER = 13_000_000,
   parameter int TW         = 26
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] en_count,
   input  logic       enUP,
   input  logic       enDOWN,
   input  logic       load,
   input  logic [7:0] load_bcd,
   input  logic       inc_in,
   input  logic       dec_in,
   output logic [7:0] data_bcd,
   output logic       carry_out,
   output logic       borrow_out,
   output logic       load_err
);

   localparam logic [7:0]    MIN_B   = to_bcd(MIN_VAL);
   localparam logic [7:0]    MAX_B   = to_bcd(MIN_VAL + MOD - 1);
   localparam logic [TW-1:0] DLY_END = TW'(REPEAT_DLY - 1);
   localparam logic [TW-1:0] PER_END = TW'(REPEAT_PER - 1);

   rep_state_t    state, state_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic          dir_q;
   logic          man_step;

   logic          press;
   logic          chain_req;
   logic          step_up;
   logic [7:0]    step_val;
   logic          step_wrap;
   logic          load_ok;

   logic [7:0]    data_nxt;
   logic          carry_nxt, borrow_nxt, err_nxt;

   // Exactly one button on the selected field is a valid manual request
   assign press     = (en_count == 4'(FIELD_ID)) && (enUP ^ enDOWN);
   assign chain_req = inc_in ^ dec_in;
   assign step_up   = man_step ? enUP : inc_in;

   // Digits valid and in range; with valid digits BCD order equals numeric order
   assign load_ok = (load_bcd[7:4] <= 4'd9) && (load_bcd[3:0] <= 4'd9) &&
                    (load_bcd >= MIN_B) && (load_bcd <= MAX_B);

   bcd_step2 #(
      .MIN_B (MIN_B),
      .MAX_B (MAX_B)
   ) u_step (
      .val  (data_bcd),
      .up   (step_up),
      .nxt  (step_val),
      .wrap (step_wrap)
   );

   // Repeat FSM state, timer and the direction of the press being held
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         timer <= '0;
         dir_q <= 1'b0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         if (state == ST_IDLE && man_step) dir_q <= enUP;
      end
   end

   // Next state: a load or any loss of a clean press returns to IDLE without stepping
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      man_step  = 1'b0;
      if (load || !press) begin
         state_nxt = ST_IDLE;
         timer_nxt = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               man_step  = 1'b1;
               state_nxt = ST_DELAY;
               timer_nxt = '0;
            end
            ST_DELAY: begin
               if (enUP != dir_q) begin
                  state_nxt = ST_IDLE;
                  timer_nxt = '0;
               end else if (timer == DLY_END) begin
                  man_step  = 1'b1;
                  state_nxt = ST_REPEAT;
                  timer_nxt = '0;
               end else begin
                  timer_nxt = timer + TW'(1);
               end
            end
            ST_REPEAT: begin
               if (enUP != dir_q) begin
                  state_nxt = ST_IDLE;
                  timer_nxt = '0;
               end else if (timer == PER_END) begin
                  man_step  = 1'b1;
                  timer_nxt = '0;
               end else begin
                  timer_nxt = timer + TW'(1);
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               timer_nxt = '0;
            end
         endcase
      end
   end

   // Output decode: load > manual step > chain; only chain wraps propagate
   always_comb begin
      data_nxt   = data_bcd;
      carry_nxt  = 1'b0;
      borrow_nxt = 1'b0;
      err_nxt    = 1'b0;
      if (load) begin
         if (load_ok) data_nxt = load_bcd;
         else         err_nxt  = 1'b1;
      end else if (man_step) begin
         data_nxt = step_val;
      end else if (chain_req) begin
         data_nxt   = step_val;
         carry_nxt  = step_wrap & inc_in;
         borrow_nxt = step_wrap & dec_in;
      end
   end

   // Registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         data_bcd   <= MIN_B;
         carry_out  <= 1'b0;
         borrow_out <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         data_bcd   <= data_nxt;
         carry_out  <= carry_nxt;
         borrow_out <= borrow_nxt;
         load_err   <= err_nxt;
      end
   end

endmodule

// File: tb/tb_contador_ad_bcd_rep.sv
// Directed bench: minutes-style instance (0..59) and month-style instance (1..12).
module tb_contador_ad_bcd_rep;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] en_count;
   logic       enUP, enDOWN, load, inc_in, dec_in;
   logic [7:0] load_bcd;
   logic [7:0] data_bcd;
   logic       carry_out, borrow_out, load_err;

   logic       m_reset;
   logic [3:0] m_en;
   logic       m_up, m_dn, m_load, m_inc, m_dec;
   logic [7:0] m_lbcd;
   logic [7:0] m_data;
   logic       m_carry, m_borrow, m_err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   contador_ad_bcd_rep #(
      .MOD(60), .MIN_VAL(0), .FIELD_ID(2), .REPEAT_DLY(4), .REPEAT_PER(2), .TW(26)
   ) dut (
      .clk(clk), .reset(reset), .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN),
      .load(load), .load_bcd(load_bcd), .inc_in(inc_in), .dec_in(dec_in),
      .data_bcd(data_bcd), .carry_out(carry_out), .borrow_out(borrow_out),
      .load_err(load_err)
   );

   contador_ad_bcd_rep #(
      .MOD(12), .MIN_VAL(1), .FIELD_ID(5), .REPEAT_DLY(4), .REPEAT_PER(2), .TW(26)
   ) dut_mes (
      .clk(clk), .reset(m_reset), .en_count(m_en), .enUP(m_up), .enDOWN(m_dn),
      .load(m_load), .load_bcd(m_lbcd), .inc_in(m_inc), .dec_in(m_dec),
      .data_bcd(m_data), .carry_out(m_carry), .borrow_out(m_borrow),
      .load_err(m_err)
   );

   typedef struct {
      logic [3:0] en;
      logic       up, dn, ld;
      logic [7:0] lb;
      logic       inc, dec;
      logic [7:0] ed;
      logic       ec, eb, ee;
   } vec_t;

   vec_t tbl[22];

   function automatic vec_t mk(input logic [3:0] en, input logic up, input logic dn,
                               input logic ld, input logic [7:0] lb, input logic inc,
                               input logic dec, input logic [7:0] ed, input logic ec,
                               input logic eb, input logic ee);
      vec_t v;
      v.en = en; v.up = up; v.dn = dn; v.ld = ld; v.lb = lb; v.inc = inc; v.dec = dec;
      v.ed = ed; v.ec = ec; v.eb = eb; v.ee = ee;
      return v;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      en_count = 4'd0; enUP = 1'b0; enDOWN = 1'b0; load = 1'b0;
      load_bcd = 8'h00; inc_in = 1'b0; dec_in = 1'b0;
   endtask

   task automatic m_idle();
      m_en = 4'd0; m_up = 1'b0; m_dn = 1'b0; m_load = 1'b0;
      m_lbcd = 8'h00; m_inc = 1'b0; m_dec = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string name, input logic [7:0] ed, input logic ec,
                            input logic eb, input logic ee);
      check({name, ".data"},   data_bcd,          ed);
      check({name, ".carry"},  {7'd0, carry_out},  {7'd0, ec});
      check({name, ".borrow"}, {7'd0, borrow_out}, {7'd0, eb});
      check({name, ".err"},    {7'd0, load_err},   {7'd0, ee});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] rep_exp[9];
      logic [7:0] rst_exp[5];

      idle_inputs();
      m_idle();
      reset = 1'b1;
      m_reset = 1'b1;
      #1;
      tick(); tick();
      check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      check("mes.reset", m_data, 8'h01);
      reset = 1'b0;
      m_reset = 1'b0;

      // Table: chain wraps, manual wrap, loads, deselect/both buttons, priorities
      tbl[0]  = mk(4'd0, 0, 0, 1, 8'h59, 0, 0, 8'h59, 0, 0, 0);
      tbl[1]  = mk(4'd0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0);
      tbl[2]  = mk(4'd0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
      tbl[3]  = mk(4'd0, 0, 0, 1, 8'h59, 0, 0, 8'h59, 0, 0, 0);
      tbl[4]  = mk(4'd2, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
      tbl[5]  = mk(4'd0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
      tbl[6]  = mk(4'd0, 0, 0, 0, 8'h00, 0, 1, 8'h59, 0, 1, 0);
      tbl[7]  = mk(4'd0, 0, 0, 0, 8'h00, 0, 0, 8'h59, 0, 0, 0);
      tbl[8]  = mk(4'd0, 0, 0, 1, 8'h37, 0, 0, 8'h37, 0, 0, 0);
      tbl[9]  = mk(4'd0, 0, 0, 1, 8'h3A, 0, 0, 8'h37, 0, 0, 1);
      tbl[10] = mk(4'd0, 0, 0, 0, 8'h00, 0, 0, 8'h37, 0, 0, 0);
      tbl[11] = mk(4'd0, 0, 0, 1, 8'h60, 0, 0, 8'h37, 0, 0, 1);
      tbl[12] = mk(4'd3, 1, 0, 0, 8'h00, 0, 0, 8'h37, 0, 0, 0);
      tbl[13] = mk(4'd2, 1, 1, 0, 8'h00, 0, 0, 8'h37, 0, 0, 0);
      tbl[14] = mk(4'd2, 1, 1, 0, 8'h00, 0, 0, 8'h37, 0, 0, 0);
      tbl[15] = mk(4'd0, 0, 0, 1, 8'h59, 1, 0, 8'h59, 0, 0, 0);
      tbl[16] = mk(4'd0, 0, 0, 0, 8'h00, 1, 1, 8'h59, 0, 0, 0);
      tbl[17] = mk(4'd0, 0, 0, 1, 8'h20, 0, 0, 8'h20, 0, 0, 0);
      tbl[18] = mk(4'd0, 0, 0, 0, 8'h00, 0, 1, 8'h19, 0, 0, 0);
      tbl[19] = mk(4'd0, 0, 0, 0, 8'h00, 1, 0, 8'h20, 0, 0, 0);
      tbl[20] = mk(4'd2, 0, 1, 0, 8'h00, 0, 0, 8'h19, 0, 0, 0);
      tbl[21] = mk(4'd0, 0, 0, 0, 8'h00, 0, 0, 8'h19, 0, 0, 0);

      for (int i = 0; i < 22; i++) begin
         en_count = tbl[i].en; enUP = tbl[i].up; enDOWN = tbl[i].dn;
         load = tbl[i].ld; load_bcd = tbl[i].lb;
         inc_in = tbl[i].inc; dec_in = tbl[i].dec;
         tick();
         check_all($sformatf("vec%0d", i), tbl[i].ed, tbl[i].ec, tbl[i].eb, tbl[i].ee);
      end
      idle_inputs();
      tick();

      // Press and auto-repeat from 00: press step, DELAY of 4, then every 2
      load = 1'b1; load_bcd = 8'h00;
      tick();
      idle_inputs();
      rep_exp = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04};
      en_count = 4'd2; enUP = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         check($sformatf("repeat.e%0d", i + 1), data_bcd, rep_exp[i]);
      end
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("release.e%0d", i + 1), data_bcd, 8'h04);
      end

      // Direction change: no step on the change edge, new press on the next
      en_count = 4'd2; enUP = 1'b1;
      tick(); check("dir.press", data_bcd, 8'h05);
      enUP = 1'b0; enDOWN = 1'b1;
      tick(); check("dir.change", data_bcd, 8'h05);
      tick(); check("dir.newpress", data_bcd, 8'h04);
      idle_inputs();
      tick();

      // Load while a button is held, then re-press on the following edge
      en_count = 4'd2; enUP = 1'b1;
      tick(); check("ldheld.press", data_bcd, 8'h05);
      load = 1'b1; load_bcd = 8'h30;
      tick(); check("ldheld.load", data_bcd, 8'h30);
      load = 1'b0;
      tick(); check("ldheld.repress", data_bcd, 8'h31);
      tick(); check("ldheld.delay", data_bcd, 8'h31);
      idle_inputs();
      tick();

      // Reset during REPEAT with enUP held, then step on deassertion and DELAY spacing
      load = 1'b1; load_bcd = 8'h00;
      tick();
      idle_inputs();
      en_count = 4'd2; enUP = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      check("rstrep.before", data_bcd, 8'h03);
      reset = 1'b1;
      tick(); tick();
      check("rstrep.reset", data_bcd, 8'h00);
      reset = 1'b0;
      rst_exp = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02};
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("rstrep.e%0d", i + 1), data_bcd, rst_exp[i]);
      end
      idle_inputs();
      tick();

      // Month instance (1..12)
      m_dec = 1'b1;
      tick(); check("mes.dec_wrap", m_data, 8'h12);
      check("mes.borrow", {7'd0, m_borrow}, 8'h01);
      m_dec = 1'b0; m_inc = 1'b1;
      tick(); check("mes.inc_wrap", m_data, 8'h01);
      check("mes.carry", {7'd0, m_carry}, 8'h01);
      m_inc = 1'b0; m_load = 1'b1; m_lbcd = 8'h09;
      tick(); check("mes.load09", m_data, 8'h09);
      m_load = 1'b0; m_inc = 1'b1;
      tick(); check("mes.bcd_carry", m_data, 8'h10);
      check("mes.no_carry", {7'd0, m_carry}, 8'h00);
      m_inc = 1'b0; m_load = 1'b1; m_lbcd = 8'h00;
      tick(); check("mes.load00", m_data, 8'h10);
      check("mes.err00", {7'd0, m_err}, 8'h01);
      m_lbcd = 8'h13;
      tick(); check("mes.load13", m_data, 8'h10);
      check("mes.err13", {7'd0, m_err}, 8'h01);
      m_load = 1'b0; m_en = 4'd5; m_dn = 1'b1;
      tick(); check("mes.man_dn", m_data, 8'h09);
      m_idle();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
